// File: rtl/banked_register_file_pkg.sv
// rtl/banked_register_file_pkg.sv - shared types and helpers for the banked register file (optional BANKED_REGFILE_BYPASS_EN)
package banked_regfile_pkg;

  // Bank-switch controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2,
    ST_ACK    = 2'd3
  } bank_state_e;

  // Per-register write source; the branch order in the write-select logic
  // gives ALU over memory over pipeline constant over inc/dec.
  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_ALU  = 3'd1,
    SRC_MEM  = 3'd2,
    SRC_PIPE = 3'd3,
    SRC_INC  = 3'd4,
    SRC_DEC  = 3'd5
  } wr_src_e;

  // Bank index width; at least one bit so the bank select is never empty
  function automatic int bank_idx_bits(input int nbanks);
    return (nbanks > 2) ? $clog2(nbanks) : 1;
  endfunction

  // Only full-value writes are forwarded; inc/dec results are not
  function automatic logic is_fwd_src(input wr_src_e s);
    return (s == SRC_ALU) || (s == SRC_MEM) || (s == SRC_PIPE);
  endfunction

endpackage

// File: rtl/banked_register_file_if.sv
// rtl/banked_register_file_if.sv - datapath, scoreboard and bank-switch signal bundle
interface banked_register_file_if
  import banked_regfile_pkg::*;
#(
  parameter int REG_BITS  = 3,
  parameter int BITS      = 16,
  parameter int NBANKS    = 2,
  parameter int BANK_BITS = bank_idx_bits(NBANKS)
);

  logic [BITS-1:0]      inALU;
  logic                 WR_ALUb;
  logic [REG_BITS-1:0]  WR_ALU_SEL;
  logic [BITS-1:0]      inM;
  logic                 WR_Mb;
  logic [REG_BITS-1:0]  WR_M_SEL;
  logic [BITS-1:0]      inP;
  logic                 WR_Pb;
  logic [REG_BITS-1:0]  WR_P_SEL;
  logic                 INCb;
  logic                 DECb;
  logic [REG_BITS-1:0]  INCDEC_SEL;
  logic                 LOAD_ISSUEb;
  logic [REG_BITS-1:0]  LOAD_SEL;
  logic [REG_BITS-1:0]  ALU_A_SEL;
  logic [REG_BITS-1:0]  ALU_B_SEL;
  logic                 ALU_B_from_inP_b;
  logic                 M_ENb;
  logic [REG_BITS-1:0]  M_SEL;
  logic [REG_BITS-1:0]  MADDR_SEL;
  logic                 MADDR_ALU_SELb;
  logic                 MADDR_POUT_SELb;
  logic                 BANK_REQ;
  logic [BANK_BITS-1:0] BANK_TGT;

  logic [BITS-1:0]      aluA_out;
  logic [BITS-1:0]      aluB_out;
  logic [BITS-1:0]      m_out;
  logic [BITS-1:0]      m_addr_out;
  logic                 stall_A;
  logic                 stall_B;
  logic                 stall_M;
  logic [BANK_BITS-1:0] bank_cur;
  logic                 bank_busy;
  logic                 bank_ack;
  logic                 sb_empty;

  modport master (
    output inALU, WR_ALUb, WR_ALU_SEL, inM, WR_Mb, WR_M_SEL, inP, WR_Pb, WR_P_SEL,
           INCb, DECb, INCDEC_SEL, LOAD_ISSUEb, LOAD_SEL, ALU_A_SEL, ALU_B_SEL,
           ALU_B_from_inP_b, M_ENb, M_SEL, MADDR_SEL, MADDR_ALU_SELb, MADDR_POUT_SELb,
           BANK_REQ, BANK_TGT,
    input  aluA_out, aluB_out, m_out, m_addr_out, stall_A, stall_B, stall_M,
           bank_cur, bank_busy, bank_ack, sb_empty
  );

  modport slave (
    input  inALU, WR_ALUb, WR_ALU_SEL, inM, WR_Mb, WR_M_SEL, inP, WR_Pb, WR_P_SEL,
           INCb, DECb, INCDEC_SEL, LOAD_ISSUEb, LOAD_SEL, ALU_A_SEL, ALU_B_SEL,
           ALU_B_from_inP_b, M_ENb, M_SEL, MADDR_SEL, MADDR_ALU_SELb, MADDR_POUT_SELb,
           BANK_REQ, BANK_TGT,
    output aluA_out, aluB_out, m_out, m_addr_out, stall_A, stall_B, stall_M,
           bank_cur, bank_busy, bank_ack, sb_empty
  );

endinterface

// File: rtl/banked_register_file_bank_ctrl.sv
// rtl/banked_register_file_bank_ctrl.sv - bank-switch request/ack controller that drains pending loads first
module regfile_bank_ctrl
  import banked_regfile_pkg::*;
#(
  parameter int NBANKS    = 2,
  parameter int BANK_BITS = bank_idx_bits(NBANKS)
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 bank_req,
  input  logic [BANK_BITS-1:0] bank_tgt,
  input  logic                 sb_next_empty,
  output logic [BANK_BITS-1:0] bank_cur,
  output logic                 bank_busy,
  output logic                 bank_ack
);

  bank_state_e          state, state_next;
  logic                 latch_tgt;
  logic [BANK_BITS-1:0] tgt_q;
  logic [BANK_BITS-1:0] tgt_wrap;

  // Out-of-range targets fold back into the implemented banks
  assign tgt_wrap = BANK_BITS'(32'(bank_tgt) % 32'(NBANKS));

  // State register, latched target and active bank
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state    <= ST_IDLE;
      tgt_q    <= '0;
      bank_cur <= '0;
    end else begin
      state <= state_next;
      if (latch_tgt) tgt_q <= tgt_wrap;
      if (state == ST_SWITCH) bank_cur <= tgt_q;
    end
  end

  // Next-state: emptiness is judged after this edge's scoreboard updates
  always_comb begin
    state_next = state;
    latch_tgt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bank_req) begin
          latch_tgt  = 1'b1;
          state_next = sb_next_empty ? ST_SWITCH : ST_DRAIN;
        end
      end
      ST_DRAIN:  if (sb_next_empty) state_next = ST_SWITCH;
      ST_SWITCH: state_next = ST_ACK;
      ST_ACK:    state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign bank_busy = (state != ST_IDLE);
  assign bank_ack  = (state == ST_ACK);

endmodule

// File: rtl/banked_register_file.sv
// rtl/banked_register_file.sv - banked register file with load scoreboard and bank switching (optional BANKED_REGFILE_BYPASS_EN)
module banked_register_file
  import banked_regfile_pkg::*;
#(
  parameter int REG_BITS  = 3,
  parameter int BITS      = 16,
  parameter int NBANKS    = 2,
  parameter int BANK_BITS = bank_idx_bits(NBANKS)
) (
  input logic                  CLK,
  input logic                  RSTb,
  banked_register_file_if.slave bus
);

  localparam int NREGS = 2 ** REG_BITS;

  logic [BITS-1:0]      regs [NBANKS][NREGS];
  logic [NREGS-1:0]     sb, sb_next, sb_vis;
  wr_src_e              src   [NREGS];
  logic [BITS-1:0]      wdata [NREGS];
  logic [BANK_BITS-1:0] bank_cur;
  logic                 bank_busy;
  logic                 bank_ack;
  logic                 load_ok;
  logic [BITS-1:0]      rd_a, rd_b, rd_m, rd_addr;

  // Resolve the winning write source and data for every register
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      src[i]   = SRC_NONE;
      wdata[i] = '0;
      if (!bus.WR_ALUb && int'(bus.WR_ALU_SEL) == i) begin
        src[i]   = SRC_ALU;
        wdata[i] = bus.inALU;
      end else if (!bus.WR_Mb && int'(bus.WR_M_SEL) == i) begin
        src[i]   = SRC_MEM;
        wdata[i] = bus.inM;
      end else if (!bus.WR_Pb && int'(bus.WR_P_SEL) == i) begin
        src[i]   = SRC_PIPE;
        wdata[i] = bus.inP;
      end else if (int'(bus.INCDEC_SEL) == i && (bus.INCb != bus.DECb)) begin
        src[i]   = !bus.INCb ? SRC_INC : SRC_DEC;
        wdata[i] = !bus.INCb ? regs[bank_cur][i] + BITS'(1) : regs[bank_cur][i] - BITS'(1);
      end
    end
  end

  // Loads issued while a switch is in progress are dropped; completions still clear
  assign load_ok = !bus.LOAD_ISSUEb && !bank_busy;

  // Scoreboard update: a new issue wins over a completion on the same index
  always_comb begin
    sb_next = sb;
    if (!bus.WR_Mb) sb_next[bus.WR_M_SEL] = 1'b0;
    if (load_ok)    sb_next[bus.LOAD_SEL] = 1'b1;
  end

  // Register storage and scoreboard state
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      for (int b = 0; b < NBANKS; b++)
        for (int i = 0; i < NREGS; i++)
          regs[b][i] <= '0;
      sb <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (src[i] != SRC_NONE) regs[bank_cur][i] <= wdata[i];
      sb <= sb_next;
    end
  end

  regfile_bank_ctrl #(
    .NBANKS    (NBANKS),
    .BANK_BITS (BANK_BITS)
  ) u_bank_ctrl (
    .clk           (CLK),
    .rst_b         (RSTb),
    .bank_req      (bus.BANK_REQ),
    .bank_tgt      (bus.BANK_TGT),
    .sb_next_empty (sb_next == '0),
    .bank_cur      (bank_cur),
    .bank_busy     (bank_busy),
    .bank_ack      (bank_ack)
  );

  // Read ports from the active bank, optionally forwarding this cycle's writes
  always_comb begin
    rd_a    = regs[bank_cur][bus.ALU_A_SEL];
    rd_b    = regs[bank_cur][bus.ALU_B_SEL];
    rd_m    = regs[bank_cur][bus.M_SEL];
    rd_addr = regs[bank_cur][bus.MADDR_SEL];
    sb_vis  = sb;
`ifdef BANKED_REGFILE_BYPASS_EN
    if (is_fwd_src(src[bus.ALU_A_SEL])) rd_a    = wdata[bus.ALU_A_SEL];
    if (is_fwd_src(src[bus.ALU_B_SEL])) rd_b    = wdata[bus.ALU_B_SEL];
    if (is_fwd_src(src[bus.M_SEL]))     rd_m    = wdata[bus.M_SEL];
    if (is_fwd_src(src[bus.MADDR_SEL])) rd_addr = wdata[bus.MADDR_SEL];
    if (!bus.WR_Mb) sb_vis[bus.WR_M_SEL] = 1'b0;
`endif
  end

  assign bus.aluA_out   = rd_a;
  assign bus.aluB_out   = bus.ALU_B_from_inP_b ? rd_b : bus.inP;
  assign bus.m_out      = bus.M_ENb ? '0 : rd_m;
  assign bus.m_addr_out = !bus.MADDR_ALU_SELb  ? bus.inALU :
                          !bus.MADDR_POUT_SELb ? bus.inP   : rd_addr;
  assign bus.stall_A    = sb_vis[bus.ALU_A_SEL];
  assign bus.stall_B    = bus.ALU_B_from_inP_b && sb_vis[bus.ALU_B_SEL];
  assign bus.stall_M    = !bus.M_ENb && sb_vis[bus.M_SEL];
  assign bus.bank_cur   = bank_cur;
  assign bus.bank_busy  = bank_busy;
  assign bus.bank_ack   = bank_ack;
  assign bus.sb_empty   = (sb == '0);

endmodule

// File: tb/tb_banked_register_file.sv
// tb/tb_banked_register_file.sv - directed self-checking bench for banked_register_file
module tb_banked_register_file;

  logic clk;
  logic rstb;
  int   tests;
  int   fails;

  banked_register_file_if #(.REG_BITS(3), .BITS(16), .NBANKS(2)) bus ();

  banked_register_file #(.REG_BITS(3), .BITS(16), .NBANKS(2)) dut (
    .CLK  (clk),
    .RSTb (rstb),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    bus.inALU = '0; bus.WR_ALUb = 1'b1; bus.WR_ALU_SEL = '0;
    bus.inM = '0;   bus.WR_Mb = 1'b1;   bus.WR_M_SEL = '0;
    bus.inP = '0;   bus.WR_Pb = 1'b1;   bus.WR_P_SEL = '0;
    bus.INCb = 1'b1; bus.DECb = 1'b1; bus.INCDEC_SEL = '0;
    bus.LOAD_ISSUEb = 1'b1; bus.LOAD_SEL = '0;
    bus.ALU_A_SEL = '0; bus.ALU_B_SEL = '0; bus.ALU_B_from_inP_b = 1'b1;
    bus.M_ENb = 1'b1; bus.M_SEL = '0; bus.MADDR_SEL = '0;
    bus.MADDR_ALU_SELb = 1'b1; bus.MADDR_POUT_SELb = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    quiet();
    bus.BANK_REQ = 1'b0;
    bus.BANK_TGT = '0;

    // Reset
    rstb = 1'b0;
    tick();
    tick();
    check("rst_sb_empty", bus.sb_empty, 1);
    check("rst_bank_cur", bus.bank_cur, 0);
    check("rst_busy", bus.bank_busy, 0);
    check("rst_ack", bus.bank_ack, 0);
    check("rst_r0", bus.aluA_out, 0);
    rstb = 1'b1;

    // ALU write r3, visible next cycle
    bus.WR_ALUb = 1'b0; bus.WR_ALU_SEL = 3; bus.inALU = 16'h1234; bus.ALU_A_SEL = 3;
    #1;
`ifdef BANKED_REGFILE_BYPASS_EN
    check("alu_r3_same_cycle", bus.aluA_out, 16'h1234);
`else
    check("alu_r3_same_cycle", bus.aluA_out, 16'h0000);
`endif
    tick();
    quiet();
    bus.ALU_A_SEL = 3;
    #1;
    check("alu_r3_next", bus.aluA_out, 16'h1234);
    for (int i = 0; i < 8; i++) begin
      if (i != 3) begin
        bus.ALU_A_SEL = 3'(i);
        #1;
        check($sformatf("other_r%0d_zero", i), bus.aluA_out, 0);
      end
    end

    // Preload r5 = 0xFFFF via pipeline constant
    bus.WR_Pb = 1'b0; bus.WR_P_SEL = 5; bus.inP = 16'hFFFF;
    tick();
    quiet();

    // ALU beats M on r2; INC r5 wraps
    bus.WR_ALUb = 1'b0; bus.WR_ALU_SEL = 2; bus.inALU = 16'h00AA;
    bus.WR_Mb = 1'b0;   bus.WR_M_SEL = 2;   bus.inM = 16'h00BB;
    bus.INCb = 1'b0;    bus.INCDEC_SEL = 5;
    tick();
    quiet();
    bus.ALU_A_SEL = 2; bus.ALU_B_SEL = 5;
    #1;
    check("alu_over_m_r2", bus.aluA_out, 16'h00AA);
    check("inc_wrap_r5", bus.aluB_out, 16'h0000);

    // DEC r6 wraps, independent M write to non-pending r7
    bus.DECb = 1'b0; bus.INCDEC_SEL = 6;
    bus.WR_Mb = 1'b0; bus.WR_M_SEL = 7; bus.inM = 16'h0077;
    tick();
    quiet();
    bus.M_ENb = 1'b0; bus.M_SEL = 6; bus.ALU_A_SEL = 7;
    #1;
    check("dec_wrap_r6", bus.m_out, 16'hFFFF);
    check("m_write_r7", bus.aluA_out, 16'h0077);
    check("m_write_no_pending", bus.sb_empty, 1);
    bus.M_ENb = 1'b1;
    #1;
    check("m_out_disabled", bus.m_out, 0);

    // INC and DEC together leave r3 unchanged
    bus.INCb = 1'b0; bus.DECb = 1'b0; bus.INCDEC_SEL = 3;
    tick();
    quiet();
    bus.ALU_A_SEL = 3;
    #1;
    check("incdec_cancel_r3", bus.aluA_out, 16'h1234);

    // Address mux priority
    bus.MADDR_SEL = 3; bus.inP = 16'hAAAA; bus.inALU = 16'h5555;
    #1;
    check("maddr_reg", bus.m_addr_out, 16'h1234);
    bus.MADDR_POUT_SELb = 1'b0;
    #1;
    check("maddr_inp", bus.m_addr_out, 16'hAAAA);
    bus.MADDR_ALU_SELb = 1'b0;
    #1;
    check("maddr_alu", bus.m_addr_out, 16'h5555);
    quiet();

    // Load scoreboard on r4
    bus.LOAD_ISSUEb = 1'b0; bus.LOAD_SEL = 4;
    tick();
    quiet();
    bus.ALU_B_SEL = 4; bus.M_SEL = 4; bus.M_ENb = 1'b0;
    #1;
    check("stall_b_pending", bus.stall_B, 1);
    check("stall_m_pending", bus.stall_M, 1);
    check("sb_not_empty", bus.sb_empty, 0);
    bus.ALU_B_from_inP_b = 1'b0; bus.inP = 16'h0C0C;
    #1;
    check("stall_b_inp", bus.stall_B, 0);
    check("aluB_inp", bus.aluB_out, 16'h0C0C);
    bus.ALU_B_from_inP_b = 1'b1;
    bus.WR_Mb = 1'b0; bus.WR_M_SEL = 4; bus.inM = 16'h5555;
    #1;
`ifdef BANKED_REGFILE_BYPASS_EN
    check("stall_b_completing", bus.stall_B, 0);
`else
    check("stall_b_completing", bus.stall_B, 1);
`endif
    tick();
    quiet();
    bus.ALU_B_SEL = 4;
    #1;
    check("stall_b_cleared", bus.stall_B, 0);
    check("aluB_r4_loaded", bus.aluB_out, 16'h5555);
    check("sb_empty_again", bus.sb_empty, 1);

    // Issue and complete r4 in one cycle: new load wins
    bus.LOAD_ISSUEb = 1'b0; bus.LOAD_SEL = 4;
    bus.WR_Mb = 1'b0; bus.WR_M_SEL = 4; bus.inM = 16'h6666;
    tick();
    quiet();
    bus.ALU_B_SEL = 4;
    #1;
    check("issue_complete_stall", bus.stall_B, 1);
    check("issue_complete_data", bus.aluB_out, 16'h6666);
    bus.WR_Mb = 1'b0; bus.WR_M_SEL = 4; bus.inM = 16'h6666;
    tick();
    quiet();
    check("sb_drained_r4", bus.sb_empty, 1);

    // Bank switch with a pending load on r1
    bus.LOAD_ISSUEb = 1'b0; bus.LOAD_SEL = 1;
    tick();
    quiet();
    bus.BANK_REQ = 1'b1; bus.BANK_TGT = 1;
    tick();
    check("drain_busy", bus.bank_busy, 1);
    check("drain_ack", bus.bank_ack, 0);
    check("drain_bank", bus.bank_cur, 0);
    bus.LOAD_ISSUEb = 1'b0; bus.LOAD_SEL = 2;
    tick();
    quiet();
    bus.ALU_A_SEL = 2;
    #1;
    check("drain_load_ignored", bus.stall_A, 0);
    check("drain_still_busy", bus.bank_busy, 1);
    bus.WR_Mb = 1'b0; bus.WR_M_SEL = 1; bus.inM = 16'h1111;
    tick();
    quiet();
    bus.ALU_A_SEL = 1;
    #1;
    check("switch_busy", bus.bank_busy, 1);
    check("switch_ack", bus.bank_ack, 0);
    check("switch_bank", bus.bank_cur, 0);
    check("switch_r1_bank0", bus.aluA_out, 16'h1111);
    tick();
    check("ack_pulse", bus.bank_ack, 1);
    check("ack_bank", bus.bank_cur, 1);
    check("ack_r1_bank1", bus.aluA_out, 0);
    bus.BANK_REQ = 1'b0;
    tick();
    check("idle_ack_low", bus.bank_ack, 0);
    check("idle_not_busy", bus.bank_busy, 0);
    check("idle_bank1", bus.bank_cur, 1);

    // Write in bank 1
    bus.WR_ALUb = 1'b0; bus.WR_ALU_SEL = 1; bus.inALU = 16'hBEEF;
    tick();
    quiet();
    bus.ALU_A_SEL = 1;
    #1;
    check("bank1_r1", bus.aluA_out, 16'hBEEF);

    // Same-bank request with empty scoreboard: two-edge handshake
    bus.BANK_REQ = 1'b1; bus.BANK_TGT = 1;
    tick();
    check("same_switch_busy", bus.bank_busy, 1);
    check("same_switch_ack", bus.bank_ack, 0);
    tick();
    check("same_ack", bus.bank_ack, 1);
    check("same_ack_bank", bus.bank_cur, 1);
    bus.BANK_REQ = 1'b0;
    tick();
    check("same_done_ack", bus.bank_ack, 0);

    // Reset in the middle of a drain
    bus.LOAD_ISSUEb = 1'b0; bus.LOAD_SEL = 0;
    tick();
    quiet();
    bus.BANK_REQ = 1'b1; bus.BANK_TGT = 0;
    tick();
    check("rdrain_busy", bus.bank_busy, 1);
    rstb = 1'b0;
    tick();
    rstb = 1'b1;
    bus.BANK_REQ = 1'b0;
    bus.ALU_A_SEL = 3;
    #1;
    check("rdrain_bank", bus.bank_cur, 0);
    check("rdrain_ack", bus.bank_ack, 0);
    check("rdrain_busy_low", bus.bank_busy, 0);
    check("rdrain_sb_empty", bus.sb_empty, 1);
    check("rdrain_r3_cleared", bus.aluA_out, 0);

    // Same-cycle read of an ALU write
    bus.WR_ALUb = 1'b0; bus.WR_ALU_SEL = 6; bus.inALU = 16'h0F0F; bus.ALU_A_SEL = 6;
    #1;
`ifdef BANKED_REGFILE_BYPASS_EN
    check("bypass_r6", bus.aluA_out, 16'h0F0F);
`else
    check("bypass_r6", bus.aluA_out, 16'h0000);
`endif
    tick();
    quiet();
    bus.ALU_A_SEL = 6;
    #1;
    check("r6_after_edge", bus.aluA_out, 16'h0F0F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
